wavegen_pdm: RTL and testbench
==============================

Name: wavegen_pdm

Overview:
Parametrised successor to the single-waveform triangle + PDM path. A phase-accumulator oscillator with programmable frequency, selectable waveform (saw, triangle, square, silent) and attenuation. It produces an unsigned PCM sample and a first-order sigma-delta 1-bit PDM stream. It sits behind the TinyTapeout top wrapper: ui_in drives its controls and uio_out carries pdm_out and PCM bits.

Parameters:
WIDTH, 16, PCM sample width in bits (>= 8)
PHASE_W, 24, phase accumulator and frequency word width (> WIDTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  oscillator advance enable; low freezes phase and pcm
freq  in  PHASE_W  phase increment per cycle (unsigned)
mode  in  2  requested waveform: 0 saw, 1 triangle, 2 square, 3 silent
atten  in  3  right-shift applied to waveform (0 = full scale)
pcm  out  WIDTH  registered unsigned sample
pdm_out  out  1  registered PDM bit
wrap  out  1  one-cycle pulse after phase accumulator carry-out
mode_active  out  2  waveform currently generated

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low and takes effect immediately when asserted, mid-operation included.
- Reset values: phase=0, pcm=0, pdm accumulator=0, pdm_out=0, wrap=0, mode_active=3 (silent).
- Phase accumulation, on each rising edge with ena=1:
  - {carry, phase} <= phase + freq, modulo 2^PHASE_W.
  - wrap <= carry.
- When ena=0: phase, pcm and mode_active hold; wrap <= 0.
- Waveform source: p = phase[PHASE_W-1 -: WIDTH], the pre-increment value.
- Waveform f(p, mode_active):
  - saw = p
  - triangle = p[MSB]==0 ? {p[WIDTH-2:0],1'b0} : ~{p[WIDTH-2:0],1'b0}
  - square = p[MSB] ? all-ones : 0
  - silent = 0
- Sample update: pcm <= f >> atten, logical shift; only on edges with ena=1. pcm lags phase by exactly one cycle.
- Mode switching is glitch-free:
  - mode_active <= mode only on an edge where carry=1, or where mode_active==3 (silent starts immediately).
  - A request for silent from a running mode waits for the next wrap.
  - With freq=0 no wrap occurs, so a running mode never changes until reset.
  - mode_active updates on the same edge as wrap is set; the new waveform appears in pcm from the following edge.
- freq and atten changes take effect on the next edge; no phase reset.
- PDM, every cycle regardless of ena:
  - {pdm_out, acc} <= acc + pcm, where acc is WIDTH bits and the sum is WIDTH+1 bits.
  - Over any 2^WIDTH consecutive cycles with constant pcm=N, exactly N ones are emitted.
  - pcm=0 gives constant 0.
- Total latency from phase to pdm_out influence: 2 cycles.

Decomposition:
- Package wavegen_pkg: MODE_SAW=2'd0, MODE_TRI=2'd1, MODE_SQUARE=2'd2, MODE_SILENT=2'd3, and the mode typedef.
- Sub-module pdm_sigma_delta (parameter WIDTH; ports clk, rst_n, sample, bit_out) holds the first-order modulator.
- Oscillator, waveform mux, attenuator and mode latch stay in wavegen_pdm.

Test Plan:
Bench parameters are WIDTH=8, PHASE_W=10.
1. Reset: run saw, assert rst_n=0 between edges -> pcm=0, pdm_out=0, wrap=0 and mode_active=3 immediately, with no clock needed; they hold through release.
2. Saw from silent: mode=0, freq=4, atten=0, ena=1 -> mode_active=0 after 1 edge; pcm=0,1,2,...,255,0; wrap pulses exactly once per 256 cycles.
3. Deferred switch: during saw at pcm≈100, set mode=1 -> saw continues to 255, wrap pulses, mode_active=1; pcm then runs 0,2,...,254,255,253,...,1 with no discontinuity before the wrap.
4. Square with attenuation: mode=2, freq=4, atten=2 -> pcm is 0 for 128 cycles then 63 for 128 cycles, repeating.
5. PDM density: saw freq=4; drop ena when pcm=64 -> pcm holds 64 and phase is frozen; pdm_out is periodic with period 4, with exactly 64 ones per 256 cycles.
6. Fast wrap and freq=0:
   - freq=512, mode=2 -> wrap pulses every 2nd cycle; pcm alternates 0/255.
   - Then set freq=0 and request mode=0 -> phase, pcm and mode_active stay fixed; no wrap occurs.

Source files
------------

// File: rtl/wavegen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_pkg
// Description : Waveform mode encodings shared by the wavegen_pdm block.
// Revision    : 1.0 - initial release
// ============================================================================
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_SILENT = 2'd3
    } mode_e;

endpackage : wavegen_pkg
`default_nettype wire

// File: rtl/pdm_sigma_delta.sv
`default_nettype none
// ============================================================================
// Module      : pdm_sigma_delta
// Description : First-order sigma-delta modulator; carry-out of the error
//               accumulator is the 1-bit PDM output.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_sigma_delta #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample,
    output logic             bit_out
);

    logic [WIDTH-1:0] r_acc;
    logic             r_bit;
    logic [WIDTH:0]   w_sum;

    // N ones per 2^WIDTH cycles for a constant sample N.
    assign w_sum = {1'b0, r_acc} + {1'b0, sample};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_bit <= 1'b0;
        end else begin
            r_acc <= w_sum[WIDTH-1:0];
            r_bit <= w_sum[WIDTH];
        end
    end

    assign bit_out = r_bit;

endmodule : pdm_sigma_delta
`default_nettype wire

// File: rtl/wavegen_pdm.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_pdm
// Description : Phase-accumulator oscillator (saw/triangle/square/silent) with
//               attenuation, PCM output and sigma-delta PDM output.
// Revision    : 1.0 - initial release
// ============================================================================
module wavegen_pdm
    import wavegen_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [PHASE_W-1:0] freq,
    input  logic [1:0]         mode,
    input  logic [2:0]         atten,
    output logic [WIDTH-1:0]   pcm,
    output logic               pdm_out,
    output logic               wrap,
    output logic [1:0]         mode_active
);

    logic [PHASE_W-1:0] r_phase;
    logic [WIDTH-1:0]   r_pcm;
    logic               r_wrap;
    mode_e              r_mode_active;

    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH-1:0]   w_tri_base;
    logic [WIDTH-1:0]   w_tri;
    logic [WIDTH-1:0]   w_wave;

    assign w_sum      = {1'b0, r_phase} + {1'b0, freq};
    assign w_carry    = w_sum[PHASE_W];
    assign w_p        = r_phase[PHASE_W-1 -: WIDTH];
    assign w_tri_base = {w_p[WIDTH-2:0], 1'b0};
    assign w_tri      = w_p[WIDTH-1] ? ~w_tri_base : w_tri_base;

    always_comb begin
        w_wave = '0;
        case (r_mode_active)
            MODE_SAW:    w_wave = w_p;
            MODE_TRI:    w_wave = w_tri;
            MODE_SQUARE: w_wave = {WIDTH{w_p[WIDTH-1]}};
            default:     w_wave = '0;
        endcase
    end

    // Mode changes only at a phase wrap so every waveform period is complete;
    // from silent there is no period to protect, so the request is taken at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase       <= '0;
            r_pcm         <= '0;
            r_wrap        <= 1'b0;
            r_mode_active <= MODE_SILENT;
        end else if (ena) begin
            r_phase <= w_sum[PHASE_W-1:0];
            r_wrap  <= w_carry;
            r_pcm   <= w_wave >> atten;
            if (w_carry || (r_mode_active == MODE_SILENT)) begin
                r_mode_active <= mode_e'(mode);
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    pdm_sigma_delta #(
        .WIDTH (WIDTH)
    ) u_pdm (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (r_pcm),
        .bit_out (pdm_out)
    );

    assign pcm         = r_pcm;
    assign wrap        = r_wrap;
    assign mode_active = r_mode_active;

endmodule : wavegen_pdm
`default_nettype wire

// File: tb/tb_wavegen_pdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_wavegen_pdm
// Description : Directed self-checking bench for wavegen_pdm (WIDTH=8, PHASE_W=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wavegen_pdm;

    localparam int WIDTH   = 8;
    localparam int PHASE_W = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic [PHASE_W-1:0] freq;
    logic [1:0]         mode;
    logic [2:0]         atten;
    logic [WIDTH-1:0]   pcm;
    logic               pdm_out;
    logic               wrap;
    logic [1:0]         mode_active;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wavegen_pdm #(
        .WIDTH   (WIDTH),
        .PHASE_W (PHASE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .freq        (freq),
        .mode        (mode),
        .atten       (atten),
        .pcm         (pcm),
        .pdm_out     (pdm_out),
        .wrap        (wrap),
        .mode_active (mode_active)
    );

    // Triangle value for an 8-bit phase index: rises by 2, then falls by 2 from 255.
    function automatic logic [7:0] tri_val(int p);
        return (p < 128) ? 8'(2 * p) : 8'(511 - 2 * p);
    endfunction

    task automatic test_reset();
        mode = 2'd0; freq = 10'd4; atten = 3'd0; ena = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (pcm !== 8'd39) begin errors++; $display("FAIL reset_pre_saw: pcm=%0d want 39", pcm); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pcm !== 8'd0) begin errors++; $display("FAIL reset_async_pcm: pcm=%0d want 0", pcm); end
        checks++;
        if (pdm_out !== 1'b0) begin errors++; $display("FAIL reset_async_pdm: pdm_out=%0b want 0", pdm_out); end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_async_wrap: wrap=%0b want 0", wrap); end
        checks++;
        if (mode_active !== 2'd3) begin errors++; $display("FAIL reset_async_mode: mode_active=%0d want 3", mode_active); end
        ena = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pcm !== 8'd0 || pdm_out !== 1'b0 || wrap !== 1'b0 || mode_active !== 2'd3) begin
            errors++;
            $display("FAIL reset_hold: pcm=%0d pdm=%0b wrap=%0b mode=%0d want 0 0 0 3",
                     pcm, pdm_out, wrap, mode_active);
        end
    endtask

    task automatic test_saw();
        int wraps = 0;
        mode = 2'd0; freq = 10'd4; atten = 3'd0; ena = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'(k - 1)) begin errors++; $display("FAIL saw_pcm[%0d]: pcm=%0d want %0d", k, pcm, 8'(k - 1)); end
            checks++;
            if (wrap !== (k == 256)) begin errors++; $display("FAIL saw_wrap[%0d]: wrap=%0b want %0b", k, wrap, (k == 256)); end
            if (k == 1) begin
                checks++;
                if (mode_active !== 2'd0) begin errors++; $display("FAIL saw_mode_start: mode_active=%0d want 0", mode_active); end
            end
            if (k >= 2 && wrap === 1'b1) wraps++;
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL saw_wrap_count: wraps=%0d want 1", wraps); end
    endtask

    task automatic test_deferred_switch();
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'(k)) begin errors++; $display("FAIL defer_saw_pcm[%0d]: pcm=%0d want %0d", k, pcm, k); end
        end
        mode = 2'd1;
        for (int k = 101; k <= 255; k++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'(k)) begin errors++; $display("FAIL defer_tail_pcm[%0d]: pcm=%0d want %0d", k, pcm, k); end
            checks++;
            if (wrap !== (k == 255)) begin errors++; $display("FAIL defer_wrap[%0d]: wrap=%0b", k, wrap); end
            checks++;
            if (mode_active !== ((k == 255) ? 2'd1 : 2'd0)) begin
                errors++; $display("FAIL defer_mode[%0d]: mode_active=%0d", k, mode_active);
            end
        end
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            checks++;
            if (pcm !== tri_val(p)) begin errors++; $display("FAIL tri_pcm[%0d]: pcm=%0d want %0d", p, pcm, tri_val(p)); end
            checks++;
            if (wrap !== (p == 255)) begin errors++; $display("FAIL tri_wrap[%0d]: wrap=%0b", p, wrap); end
            checks++;
            if (mode_active !== 2'd1) begin errors++; $display("FAIL tri_mode[%0d]: mode_active=%0d want 1", p, mode_active); end
        end
    endtask

    task automatic test_square_atten();
        mode = 2'd2; atten = 3'd2;
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            checks++;
            if (pcm !== (tri_val(p) >> 2)) begin
                errors++; $display("FAIL tri_atten_pcm[%0d]: pcm=%0d want %0d", p, pcm, tri_val(p) >> 2);
            end
        end
        checks++;
        if (mode_active !== 2'd2 || wrap !== 1'b1) begin
            errors++; $display("FAIL sq_switch: mode_active=%0d wrap=%0b want 2 1", mode_active, wrap);
        end
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            checks++;
            if (pcm !== (((n % 256) < 128) ? 8'd0 : 8'd63)) begin
                errors++; $display("FAIL sq_pcm[%0d]: pcm=%0d", n, pcm);
            end
            checks++;
            if (wrap !== ((n % 256) == 255)) begin errors++; $display("FAIL sq_wrap[%0d]: wrap=%0b", n, wrap); end
        end
    endtask

    task automatic test_pdm_density();
        int ones = 0;
        logic [3:0] hist = 4'b0;
        mode = 2'd0; atten = 3'd0;
        for (int p = 0; p < 256; p++) begin
            @(negedge clk);
            checks++;
            if (pcm !== ((p < 128) ? 8'd0 : 8'd255)) begin errors++; $display("FAIL sq_full_pcm[%0d]: pcm=%0d", p, pcm); end
        end
        for (int p = 0; p <= 64; p++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'(p)) begin errors++; $display("FAIL pdm_ramp_pcm[%0d]: pcm=%0d want %0d", p, pcm, p); end
        end
        ena = 1'b0;
        for (int i = 0; i < 258; i++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'd64 || wrap !== 1'b0 || mode_active !== 2'd0) begin
                errors++; $display("FAIL pdm_hold[%0d]: pcm=%0d wrap=%0b mode=%0d want 64 0 0", i, pcm, wrap, mode_active);
            end
            if (i >= 6) begin
                checks++;
                if (pdm_out !== hist[3]) begin errors++; $display("FAIL pdm_period[%0d]: bit=%0b want %0b", i, pdm_out, hist[3]); end
            end
            hist = {hist[2:0], pdm_out};
            if (i >= 2 && pdm_out === 1'b1) ones++;
        end
        checks++;
        if (ones != 64) begin errors++; $display("FAIL pdm_density: ones=%0d want 64", ones); end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (pcm !== 8'd65) begin errors++; $display("FAIL pdm_resume: pcm=%0d want 65", pcm); end
    endtask

    task automatic test_fast_wrap();
        freq = 10'd512; mode = 2'd2;
        @(negedge clk);
        checks++;
        if (pcm !== 8'd66 || wrap !== 1'b0 || mode_active !== 2'd0) begin
            errors++; $display("FAIL fast_a: pcm=%0d wrap=%0b mode=%0d want 66 0 0", pcm, wrap, mode_active);
        end
        @(negedge clk);
        checks++;
        if (pcm !== 8'd194 || wrap !== 1'b1 || mode_active !== 2'd2) begin
            errors++; $display("FAIL fast_b: pcm=%0d wrap=%0b mode=%0d want 194 1 2", pcm, wrap, mode_active);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (pcm !== ((i % 2) ? 8'd255 : 8'd0) || wrap !== (i % 2 == 1)) begin
                errors++; $display("FAIL fast_alt[%0d]: pcm=%0d wrap=%0b", i, pcm, wrap);
            end
        end
        freq = 10'd0; mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (pcm !== 8'd0 || wrap !== 1'b0 || mode_active !== 2'd2) begin
                errors++; $display("FAIL freq0[%0d]: pcm=%0d wrap=%0b mode=%0d want 0 0 2", i, pcm, wrap, mode_active);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; freq = '0; mode = 2'd0; atten = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_saw();
        test_deferred_switch();
        test_square_atten();
        test_pdm_density();
        test_fast_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wavegen_pdm
`default_nettype wire
